// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 pattern generator.
// Latency: n/a (constants only).
// Backpressure: n/a.
package max7219_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [1:0] MODE_CASCADE  = 2'd0;
  localparam logic [1:0] MODE_BCD_UP   = 2'd1;
  localparam logic [1:0] MODE_HEX_UP   = 2'd2;
  localparam logic [1:0] MODE_BCD_DOWN = 2'd3;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/max7219_bcd_digit.sv
// One decimal digit step: computes the next value and the carry/borrow to the next digit.
// Latency: purely combinational; the owning register lives in the top.
// Backpressure: none; en_i low leaves the digit unchanged, clr_i forces zero.
module max7219_bcd_digit
  import max7219_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic               up_i,
  input  logic               en_i,
  input  logic               clr_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               carry_o
);

  // Next digit value and carry/borrow; out-of-range nibbles counting up fold to 0.
  always_comb begin
    digit_o = digit_i;
    carry_o = 1'b0;
    if (clr_i) begin
      digit_o = '0;
    end else if (en_i) begin
      if (up_i) begin
        if (digit_i >= BCD_MAX) begin
          digit_o = '0;
          carry_o = 1'b1;
        end else begin
          digit_o = digit_i + DIGIT_W'(1);
        end
      end else begin
        if (digit_i == '0) begin
          digit_o = BCD_MAX;
          carry_o = 1'b1;
        end else begin
          digit_o = digit_i - DIGIT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/max7219_pattern_gen.sv
// Test-pattern source for MAX7219 digit/dot inputs; MAX7219_DOT_BOUNCE_EN makes DOT ping-pong.
// Latency: DATA/DOT change on the prescaler wrap edge; TICK is high the cycle after, with new DATA.
// Backpressure: none; HOLD freezes DATA/DOT/counters while prescaler and TICK keep running.
module max7219_pattern_gen
  import max7219_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int PRESCALE_W = 21,
  parameter int DOT_DIV    = 8
) (
  input  logic                        CLK_IN,
  input  logic                        RST,
  input  logic [1:0]                  MODE,
  input  logic                        HOLD,
  output logic [DIGIT_W*DIGITS-1:0]   DATA,
  output logic [DIGITS-1:0]           DOT,
  output logic                        TICK
);

  localparam int DATA_W = DIGIT_W * DIGITS;
  localparam int DIV_W  = (DOT_DIV > 1) ? $clog2(DOT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DOT_DIV - 1);

  logic [PRESCALE_W-1:0] prescaler_q, prescaler_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [DIGITS-1:0]     t_q, t_d;
  logic [DIGITS-1:0]     dot_q, dot_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  tick_q, tick_d;
`ifdef MAX7219_DOT_BOUNCE_EN
  logic                  dir_up_q, dir_up_d;
`endif

  logic                  tick_int;
  logic                  mode_sw;
  logic                  adv;
  logic                  bcd_en;
  logic                  bcd_up;
  logic [DATA_W-1:0]     bcd_next;
  logic                  casc_en;
  logic                  bcd_wrap_unused;

  assign tick_int = &prescaler_q;
  assign mode_sw  = (mode_q != MODE);
  // A mode-switch edge swallows a coincident tick entirely.
  assign adv      = tick_int & ~HOLD & ~mode_sw;
  assign bcd_up   = (mode_q == MODE_BCD_UP);
  assign bcd_en   = adv & ((mode_q == MODE_BCD_UP) | (mode_q == MODE_BCD_DOWN));

  // Ripple decimal counter: each digit enabled by the previous digit's carry/borrow.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic cin;
    logic cout;
    if (g == 0) begin : g_first
      assign cin = bcd_en;
    end else begin : g_chain
      assign cin = g_digit[g-1].cout;
    end
    max7219_bcd_digit u_digit (
      .digit_i (data_q[DIGIT_W*g +: DIGIT_W]),
      .up_i    (bcd_up),
      .en_i    (cin),
      .clr_i   (mode_sw),
      .digit_o (bcd_next[DIGIT_W*g +: DIGIT_W]),
      .carry_o (cout)
    );
  end
  // Full-counter wrap needs no action: the digits already land on 0s or 9s.
  assign bcd_wrap_unused = g_digit[DIGITS-1].cout;

  // Free-running prescaler, mode sampling and the registered tick strobe.
  always_comb begin
    prescaler_d = prescaler_q + PRESCALE_W'(1);
    mode_d      = MODE;
    tick_d      = tick_int;
  end

  // Digit data: clear on mode switch, otherwise advance per mode on unheld ticks.
  always_comb begin
    data_d  = data_q;
    t_d     = t_q;
    casc_en = 1'b1;
    if (mode_sw) begin
      data_d = '0;
      t_d    = '0;
    end else if (adv) begin
      case (mode_q)
        MODE_CASCADE: begin
          t_d = t_q + DIGITS'(1);
          // digit i steps when all lower tick-counter bits are ones
          for (int i = 0; i < DIGITS; i++) begin
            if (casc_en) begin
              data_d[DIGIT_W*i +: DIGIT_W] = data_q[DIGIT_W*i +: DIGIT_W] + DIGIT_W'(1);
            end
            casc_en = casc_en & t_q[i];
          end
        end
        MODE_HEX_UP: data_d = data_q + DATA_W'(1);
        default:     data_d = bcd_next;
      endcase
    end
  end

  // Dot divider and dot movement on every DOT_DIV-th unheld tick.
  always_comb begin
    dot_d = dot_q;
    div_d = div_q;
`ifdef MAX7219_DOT_BOUNCE_EN
    dir_up_d = dir_up_q;
`endif
    if (adv) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
`ifdef MAX7219_DOT_BOUNCE_EN
        if (DIGITS > 1) begin
          if (dir_up_q) begin
            if (dot_q[DIGITS-1]) begin
              dot_d    = dot_q >> 1;
              dir_up_d = 1'b0;
            end else begin
              dot_d = dot_q << 1;
            end
          end else begin
            if (dot_q[0]) begin
              dot_d    = dot_q << 1;
              dir_up_d = 1'b1;
            end else begin
              dot_d = dot_q >> 1;
            end
          end
        end
`else
        // rotate right: bit0 wraps to bit DIGITS-1
        dot_d = (dot_q >> 1) | (dot_q << (DIGITS - 1));
`endif
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK_IN or negedge RST) begin
    if (!RST) begin
      prescaler_q <= '0;
      mode_q      <= MODE_CASCADE;
      data_q      <= '0;
      t_q         <= '0;
      dot_q       <= DIGITS'(1);
      div_q       <= '0;
      tick_q      <= 1'b0;
`ifdef MAX7219_DOT_BOUNCE_EN
      dir_up_q    <= 1'b1;
`endif
    end else begin
      prescaler_q <= prescaler_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      t_q         <= t_d;
      dot_q       <= dot_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
`ifdef MAX7219_DOT_BOUNCE_EN
      dir_up_q    <= dir_up_d;
`endif
    end
  end

  assign DATA = data_q;
  assign DOT  = dot_q;
  assign TICK = tick_q;

endmodule
